udp_frame_buffer: RTL
=====================

# udp_frame_buffer

Parametrised, double-buffered UDP/IPv4 Ethernet frame store. It generates the preamble and the Ethernet/IPv4/UDP headers from parameters, including the lengths and the per-frame IPv4 header checksum. The payload is held in two banks: the camera side fills one bank while the MAC transmitter reads the other. It sits between the pixel packer (write side) and the Ethernet TX serializer (read side).

## Interface
- PAYLOAD_LEN, 1346, payload bytes per frame (≥1); UDP len = PAYLOAD_LEN+8, IP total len = PAYLOAD_LEN+28
- ADDR_W, 11, width of rd_addr/wr_addr; 2^ADDR_W ≥ PAYLOAD_LEN+50
- DST_MAC, 48'hffffffffffff, destination MAC
- SRC_MAC, 48'hd03745f66d9c, source MAC
- SRC_IP, 32'hc0a80102, source IPv4
- DST_IP, 32'ha9fea3a1, destination IPv4
- SRC_PORT, 16'hf152, UDP source port
- DST_PORT, 16'h4e21, UDP destination port
- TTL, 8'h80, IPv4 TTL
- IP_ID_INIT, 16'haa71, IPv4 identification after reset

- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  payload byte write strobe
- wr_addr  in  ADDR_W  payload byte index into fill bank
- wr_data  in  8  payload byte
- commit  in  1  fill bank complete; request swap
- commit_drop  out  1  one-cycle pulse: commit refused
- drop_cnt  out  16  refused commits, saturating
- frame_valid  out  1  frame ready to transmit
- tx_start  in  1  transmitter accepts frame
- tx_done  in  1  transmitter finished frame
- rd_addr  in  ADDR_W  frame byte index (0 = first preamble byte)
- rd_data  out  8  frame byte, registered

## Operation
- Frame layout, rd_addr:
  - 0–6: 8'h55; 7: 8'hd5
  - 8–13: DST_MAC; 14–19: SRC_MAC; 20–21: 16'h0800
  - 22–23: 16'h4500; 24–25: IP total len; 26–27: ip_id; 28–29: 16'h4000
  - 30: TTL; 31: 8'h11; 32–33: checksum
  - 34–37: SRC_IP; 38–41: DST_IP; 42–43: SRC_PORT; 44–45: DST_PORT
  - 46–47: UDP len; 48–49: 16'h0000
  - 50..PAYLOAD_LEN+49: tx bank[rd_addr−50]; beyond that: 8'h00
- All multi-byte fields are big-endian.
- Writes:
  - wr_en writes the fill bank whenever wr_addr < PAYLOAD_LEN; other addresses are ignored.
  - Writing is allowed in every state.
- State machine, states IDLE, SUM, FOLD, READY, SENDING:
  - IDLE: on commit, swap banks (tx_bank ← fill_bank, fill_bank toggles), clear acc and word index, go to SUM.
  - SUM: acc += header word k, for k = 0..9: 4500, IP total len, ip_id, 4000, {TTL,11}, 0000, SRC_IP hi, SRC_IP lo, DST_IP hi, DST_IP lo. After k = 9, go to FOLD.
  - FOLD: s = acc[15:0] + acc[19:16]; checksum ← ~(s[15:0] + s[16]); go to READY.
  - READY: frame_valid = 1; on tx_start, go to SENDING.
  - SENDING: on tx_done, ip_id ← ip_id+1 (wraps at 16 bits), go to IDLE.
- Arithmetic: acc is 20 bits and cannot overflow for 10 words.
- Commit outside IDLE is refused: commit_drop pulses, drop_cnt increments (saturates at 16'hffff), no swap, and the fill bank contents are kept.
- tx_start outside READY and tx_done outside SENDING are ignored.
- Payload reads always come from tx_bank. The header reflects the current checksum and ip_id.

## Timing
- rd_data: one-cycle latency (byte for rd_addr sampled at edge N appears after edge N).
- Commit sampled at edge T: SUM accumulates on edges T+1..T+10, FOLD on edge T+11, frame_valid high after edge T+11.
- frame_valid falls after the edge that samples tx_start.
- commit_drop and drop_cnt update on the edge that samples the refused commit.
- wr_en together with commit in IDLE: the byte lands in the bank being committed.
- commit together with tx_done in SENDING: commit is refused.
- Reset values (asynchronous): state IDLE, fill_bank 0, tx_bank 1, ip_id = IP_ID_INIT, checksum 0, acc 0, rd_data 0, frame_valid 0, commit_drop 0, drop_cnt 0. RAM contents are not reset.
- Reset mid-frame abandons the frame; the next commit starts from IDLE.

## Test plan
- Defaults: write 0x00..0x41 to payload 0..65, commit, wait for frame_valid → exactly 11 cycles after commit. Read 0..115 → bytes 24–25 = 05 5e, 26–27 = aa 71, 32–33 = 3b d3, 46–47 = 05 4a, 50–115 = written data.
- tx_start, tx_done, fill, commit → second frame ip_id = aa72, checksum = 3b d2; payload from the other bank.
- Commit while in READY → commit_drop = 1 for one cycle, drop_cnt = 1; tx bank data and checksum unchanged.
- Write the fill bank during SENDING, read payload → tx bank bytes unchanged; after tx_done and commit, the new bytes appear.
- Assert rst_n = 0 in SUM → frame_valid 0, rd_data 0, ip_id aa71; a fresh commit yields checksum 3bd3.
- rd_addr = PAYLOAD_LEN+50 → 00; wr_addr = PAYLOAD_LEN → no RAM change.

Source files
------------

// File: rtl/udp_frame_buffer.sv
// Double-buffered UDP/IPv4 Ethernet frame store: header generated from parameters, payload
// held in two banks swapped on commit, IPv4 header checksum computed once per frame.
`timescale 1ns/1ps

module udp_frame_buffer #(
    parameter int unsigned PAYLOAD_LEN = 1346,
    parameter int unsigned ADDR_W      = 11,
    parameter logic [47:0] DST_MAC     = 48'hffffffffffff,
    parameter logic [47:0] SRC_MAC     = 48'hd03745f66d9c,
    parameter logic [31:0] SRC_IP      = 32'hc0a80102,
    parameter logic [31:0] DST_IP      = 32'ha9fea3a1,
    parameter logic [15:0] SRC_PORT    = 16'hf152,
    parameter logic [15:0] DST_PORT    = 16'h4e21,
    parameter logic [7:0]  TTL         = 8'h80,
    parameter logic [15:0] IP_ID_INIT  = 16'haa71
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              commit,
    output logic              commit_drop,
    output logic [15:0]       drop_cnt,
    output logic              frame_valid,
    input  logic              tx_start,
    input  logic              tx_done,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    localparam int unsigned HdrLen = 50;
    localparam logic [15:0] IpLen  = 16'(PAYLOAD_LEN + 28);
    localparam logic [15:0] UdpLen = 16'(PAYLOAD_LEN + 8);

    typedef enum logic [2:0] {StIdle, StSum, StFold, StReady, StSending} state_e;

    state_e      state_q, state_d;
    logic        fill_bank_q, fill_bank_d;
    logic        tx_bank_q, tx_bank_d;
    logic [19:0] acc_q, acc_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] checksum_q, checksum_d;
    logic [15:0] ip_id_q, ip_id_d;
    logic        commit_drop_q, commit_drop_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [7:0]  rd_data_q, rd_data_d;

    logic [7:0]  bank0_mem [PAYLOAD_LEN];
    logic [7:0]  bank1_mem [PAYLOAD_LEN];

    logic [31:0]         wa, ra;
    logic [15:0]         sum_word;
    logic [16:0]         fold_s;
    logic [HdrLen*8-1:0] hdr;
    logic [8:0]          hdr_bit;
    logic [ADDR_W-1:0]   pay_idx;

    assign wa = 32'(wr_addr);
    assign ra = 32'(rd_addr);

    assign hdr = {{7{8'h55}}, 8'hd5, DST_MAC, SRC_MAC, 16'h0800,
                  16'h4500, IpLen, ip_id_q, 16'h4000, TTL, 8'h11, checksum_q,
                  SRC_IP, DST_IP, SRC_PORT, DST_PORT, UdpLen, 16'h0000};

    always_comb begin
        unique case (idx_q)
            4'd0:    sum_word = 16'h4500;
            4'd1:    sum_word = IpLen;
            4'd2:    sum_word = ip_id_q;
            4'd3:    sum_word = 16'h4000;
            4'd4:    sum_word = {TTL, 8'h11};
            4'd5:    sum_word = 16'h0000;
            4'd6:    sum_word = SRC_IP[31:16];
            4'd7:    sum_word = SRC_IP[15:0];
            4'd8:    sum_word = DST_IP[31:16];
            default: sum_word = DST_IP[15:0];
        endcase
    end

    always_comb begin
        state_d       = state_q;
        fill_bank_d   = fill_bank_q;
        tx_bank_d     = tx_bank_q;
        acc_d         = acc_q;
        idx_d         = idx_q;
        checksum_d    = checksum_q;
        ip_id_d       = ip_id_q;
        drop_cnt_d    = drop_cnt_q;
        commit_drop_d = 1'b0;
        fold_s        = {1'b0, acc_q[15:0]} + {13'b0, acc_q[19:16]};

        case (state_q)
            StIdle: begin
                if (commit) begin
                    tx_bank_d   = fill_bank_q;
                    fill_bank_d = ~fill_bank_q;
                    acc_d       = '0;
                    idx_d       = '0;
                    state_d     = StSum;
                end
            end
            StSum: begin
                acc_d = acc_q + {4'b0, sum_word};
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd9) state_d = StFold;
            end
            StFold: begin
                checksum_d = ~(fold_s[15:0] + {15'b0, fold_s[16]});
                state_d    = StReady;
            end
            StReady: begin
                if (tx_start) state_d = StSending;
            end
            StSending: begin
                if (tx_done) begin
                    ip_id_d = ip_id_q + 16'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Any commit outside IDLE is refused, including one coinciding with tx_done.
        if (commit && (state_q != StIdle)) begin
            commit_drop_d = 1'b1;
            if (drop_cnt_q != 16'hffff) drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_comb begin
        hdr_bit   = 9'(HdrLen * 8 - 8 - 8 * ra);
        pay_idx   = ADDR_W'(ra - HdrLen);
        rd_data_d = 8'h00;
        if (ra < HdrLen) begin
            rd_data_d = hdr[hdr_bit +: 8];
        end else if (ra < PAYLOAD_LEN + HdrLen) begin
            rd_data_d = tx_bank_q ? bank1_mem[pay_idx] : bank0_mem[pay_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            fill_bank_q   <= 1'b0;
            tx_bank_q     <= 1'b1;
            acc_q         <= '0;
            idx_q         <= '0;
            checksum_q    <= '0;
            ip_id_q       <= IP_ID_INIT;
            commit_drop_q <= 1'b0;
            drop_cnt_q    <= '0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            fill_bank_q   <= fill_bank_d;
            tx_bank_q     <= tx_bank_d;
            acc_q         <= acc_d;
            idx_q         <= idx_d;
            checksum_q    <= checksum_d;
            ip_id_q       <= ip_id_d;
            commit_drop_q <= commit_drop_d;
            drop_cnt_q    <= drop_cnt_d;
            rd_data_q     <= rd_data_d;
        end
    end

    // Payload RAM is not reset; the write uses the pre-swap fill bank on a commit edge.
    always_ff @(posedge clk) begin
        if (wr_en && (wa < PAYLOAD_LEN)) begin
            if (fill_bank_q) bank1_mem[wr_addr] <= wr_data;
            else             bank0_mem[wr_addr] <= wr_data;
        end
    end

    assign commit_drop = commit_drop_q;
    assign drop_cnt    = drop_cnt_q;
    assign frame_valid = (state_q == StReady);
    assign rd_data     = rd_data_q;

endmodule
